chart_sequencer: RTL and testbench

Step-chart reader that produces the per-lane arrow spawn mask consumed by the arrow scroller's `display_signal` input. Reads one chart row per beat from a synchronous chart ROM and presents each row's 4-bit lane mask for exactly one frame period, so the scroller samples it once on its next `frame_clk` rising edge. Sits between the chart ROM and the arrow scroller, controlled by the game-level start/pause/abort logic.

---
 rtl/chart_pkg.sv | 22 ++
 rtl/chart_sequencer_frame_tick.sv | 19 +
 rtl/chart_sequencer.sv | 127 ++++++++++++
 tb/tb_chart_sequencer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/chart_pkg.sv
// Shared types for the step-chart sequencer: FSM states and the chart ROM word layout.
package chart_pkg;

    localparam int LANE_W  = 4;
    localparam int END_BIT = 7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_WAIT,
        S_DONE
    } chart_state_t;

    // One chart ROM word: END flag, three ignored bits, lane spawn mask.
    typedef struct packed {
        logic              is_end;
        logic [2:0]        rsvd;
        logic [LANE_W-1:0] mask;
    } chart_row_t;

endpackage

// File: rtl/chart_sequencer_frame_tick.sv
// Rising-edge detector on the frame tick level; delay starts high so reset release
// with frame_clk already high does not produce a spurious edge.
module frame_tick (
    input  logic Clk,
    input  logic reset_n,
    input  logic frame_clk,
    output logic tick
);

    logic frame_dly;

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) frame_dly <= 1'b1;
        else          frame_dly <= frame_clk;
    end

    assign tick = frame_clk & ~frame_dly;

endmodule

// File: rtl/chart_sequencer.sv
// Step-chart reader: fetches one ROM row per beat and presents its lane mask to the
// arrow scroller for exactly one frame period.
module chart_sequencer
    import chart_pkg::*;
#(
    parameter int ADDR_W         = 10,
    parameter int FRAMES_PER_ROW = 8
) (
    input  logic              Clk,
    input  logic              reset_n,
    input  logic              frame_clk,
    input  logic              start,
    input  logic              pause,
    input  logic              abort,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [LANE_W-1:0] display_signal,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = (FRAMES_PER_ROW > 1) ? $clog2(FRAMES_PER_ROW) : 1;
    localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(FRAMES_PER_ROW - 1);
    localparam logic [ADDR_W-1:0] ADDR_MAX   = '1;

    chart_state_t      state, state_nxt;
    logic [CNT_W-1:0]  frame_cnt, frame_cnt_nxt;
    logic [ADDR_W-1:0] rom_addr_nxt;
    logic              last, last_nxt;
    logic              row_end, row_end_nxt;
    logic [LANE_W-1:0] row_mask, row_mask_nxt;
    logic [LANE_W-1:0] display_nxt;
    logic              tick;
    chart_row_t        rom_row;
    logic              rsvd_unused;

    assign rom_row     = chart_row_t'(rom_data);
    assign rsvd_unused = ^rom_row.rsvd;

    frame_tick u_tick (
        .Clk       (Clk),
        .reset_n   (reset_n),
        .frame_clk (frame_clk),
        .tick      (tick)
    );

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt      <= '0;
            rom_addr       <= '0;
            last           <= 1'b0;
            row_end        <= 1'b0;
            row_mask       <= '0;
            display_signal <= '0;
        end else begin
            frame_cnt      <= frame_cnt_nxt;
            rom_addr       <= rom_addr_nxt;
            last           <= last_nxt;
            row_end        <= row_end_nxt;
            row_mask       <= row_mask_nxt;
            display_signal <= display_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        frame_cnt_nxt = frame_cnt;
        rom_addr_nxt  = rom_addr;
        last_nxt      = last;
        row_end_nxt   = row_end;
        row_mask_nxt  = row_mask;
        // Every frame edge clears the mask unless a row is emitted below,
        // so a nonzero mask is held for exactly one frame period.
        display_nxt   = tick ? '0 : display_signal;

        if (abort) begin
            state_nxt     = S_IDLE;
            display_nxt   = '0;
            rom_addr_nxt  = '0;
            frame_cnt_nxt = '0;
            last_nxt      = 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        rom_addr_nxt  = '0;
                        frame_cnt_nxt = '0;
                        last_nxt      = 1'b0;
                        state_nxt     = S_FETCH;
                    end
                end
                S_FETCH: state_nxt = S_LATCH;
                S_LATCH: begin
                    row_end_nxt  = rom_row.is_end;
                    row_mask_nxt = rom_row.mask;
                    state_nxt    = S_WAIT;
                end
                S_WAIT: begin
                    if (tick && !pause) begin
                        if (frame_cnt != '0) begin
                            frame_cnt_nxt = frame_cnt - 1'b1;
                        end else if (row_end || last) begin
                            state_nxt = S_DONE;
                        end else begin
                            display_nxt   = row_mask;
                            frame_cnt_nxt = CNT_RELOAD;
                            // Address saturates; the next boundary then acts as END.
                            if (rom_addr == ADDR_MAX) last_nxt     = 1'b1;
                            else                      rom_addr_nxt = rom_addr + 1'b1;
                            state_nxt = S_FETCH;
                        end
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    assign busy = (state == S_FETCH) || (state == S_LATCH) || (state == S_WAIT);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_chart_sequencer.sv
// Directed bench for chart_sequencer: a 3-row chart at FRAMES_PER_ROW=2 and an
// 8-row END-less chart at FRAMES_PER_ROW=1, both fed by synchronous ROM models.
module tb_chart_sequencer;

    logic clk = 1'b0;
    logic rst_n, frame_clk, start_a, start_b, pause, abort;
    logic [9:0] addr_a;
    logic [2:0] addr_b;
    logic [7:0] data_a, data_b;
    logic [3:0] disp_a, disp_b;
    logic busy_a, done_a, busy_b, done_b;
    logic [7:0] rom_a [0:1023];
    int pass_cnt = 0;
    int chk_cnt  = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        data_a <= rom_a[addr_a];
        data_b <= 8'h01;
    end

    chart_sequencer #(.ADDR_W(10), .FRAMES_PER_ROW(2)) dut (
        .Clk(clk), .reset_n(rst_n), .frame_clk(frame_clk), .start(start_a),
        .pause(pause), .abort(abort), .rom_addr(addr_a), .rom_data(data_a),
        .display_signal(disp_a), .busy(busy_a), .done(done_a)
    );

    chart_sequencer #(.ADDR_W(3), .FRAMES_PER_ROW(1)) dut_s (
        .Clk(clk), .reset_n(rst_n), .frame_clk(frame_clk), .start(start_b),
        .pause(pause), .abort(abort), .rom_addr(addr_b), .rom_data(data_b),
        .display_signal(disp_b), .busy(busy_b), .done(done_b)
    );

    // Four-cycle frame; returns one negedge after the frame edge was processed.
    task automatic frame();
        @(negedge clk) frame_clk = 1'b0;
        @(negedge clk);
        @(negedge clk) frame_clk = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_start_a();
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; frame_clk = 1'b1; start_a = 0; start_b = 0; pause = 0; abort = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk_cnt++;
            if (dut.u_tick.tick !== 1'b0) $display("FAIL reset_tick cyc %0d: got %b want 0", i, dut.u_tick.tick);
            else pass_cnt++;
        end
        chk_cnt++;
        if ({disp_a, addr_a, busy_a, done_a} !== 16'h0)
            $display("FAIL reset_outs: got disp=%b addr=%0d busy=%b done=%b want all 0", disp_a, addr_a, busy_a, done_a);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            frame();
            chk_cnt++;
            if ({disp_a, disp_b, busy_a, done_a, busy_b, done_b} !== 12'h0)
                $display("FAIL reset_idle frame %0d: got disp_a=%b disp_b=%b busy=%b%b done=%b%b want 0",
                         i, disp_a, disp_b, busy_a, busy_b, done_a, done_b);
            else pass_cnt++;
        end
    endtask

    task automatic test_basic();
        logic [3:0] exp [5] = '{4'b0010, 4'b0000, 4'b1001, 4'b0000, 4'b0000};
        pulse_start_a();
        chk_cnt++;
        if (busy_a !== 1'b1) $display("FAIL basic_busy: got %b want 1", busy_a);
        else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            frame();
            chk_cnt++;
            if (disp_a !== exp[i]) $display("FAIL basic_disp edge %0d: got %b want %b", i + 1, disp_a, exp[i]);
            else pass_cnt++;
            chk_cnt++;
            if (done_a !== (i == 4)) $display("FAIL basic_done edge %0d: got %b want %b", i + 1, done_a, (i == 4));
            else pass_cnt++;
        end
        chk_cnt++;
        if (busy_a !== 1'b0) $display("FAIL basic_busy_end: got %b want 0", busy_a);
        else pass_cnt++;
    endtask

    task automatic test_pause();
        logic [3:0] exp [6] = '{4'b0010, 4'b0000, 4'b0000, 4'b1001, 4'b0000, 4'b0000};
        pulse_start_a();
        chk_cnt++;
        if (done_a !== 1'b0 || busy_a !== 1'b1)
            $display("FAIL restart_done: got done=%b busy=%b want done=0 busy=1", done_a, busy_a);
        else pass_cnt++;
        for (int i = 0; i < 6; i++) begin
            if (i == 2) pause = 1'b1;
            frame();
            pause = 1'b0;
            chk_cnt++;
            if (disp_a !== exp[i]) $display("FAIL pause_disp edge %0d: got %b want %b", i + 1, disp_a, exp[i]);
            else pass_cnt++;
            if (i >= 4) begin
                chk_cnt++;
                if (done_a !== (i == 5)) $display("FAIL pause_done edge %0d: got %b want %b", i + 1, done_a, (i == 5));
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [3:0] exp [5] = '{4'b0010, 4'b0000, 4'b1001, 4'b0000, 4'b0000};
        pulse_start_a();
        for (int i = 0; i < 5; i++) begin
            frame();
            chk_cnt++;
            if (disp_a !== exp[i]) $display("FAIL ignore_disp edge %0d: got %b want %b", i + 1, disp_a, exp[i]);
            else pass_cnt++;
            if (i == 0 || i == 2) pulse_start_a();
        end
        chk_cnt++;
        if (done_a !== 1'b1) $display("FAIL ignore_done: got %b want 1", done_a);
        else pass_cnt++;
    endtask

    task automatic test_abort();
        pulse_start_a();
        frame(); frame(); frame();
        @(negedge clk);
        @(negedge clk);
        chk_cnt++;
        if (disp_a !== 4'b1001 || busy_a !== 1'b1)
            $display("FAIL abort_pre: got disp=%b busy=%b want 1001/1", disp_a, busy_a);
        else pass_cnt++;
        abort = 1'b1; start_a = 1'b1;
        @(negedge clk) abort = 1'b0; start_a = 1'b0;
        chk_cnt++;
        if (disp_a !== 4'b0000 || busy_a !== 1'b0 || addr_a !== 10'd0 || done_a !== 1'b0)
            $display("FAIL abort_state: got disp=%b busy=%b addr=%0d done=%b want 0/0/0/0",
                     disp_a, busy_a, addr_a, done_a);
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if (busy_a !== 1'b0) $display("FAIL abort_wins: got busy=%b want 0", busy_a);
        else pass_cnt++;
        pulse_start_a();
        frame();
        chk_cnt++;
        if (disp_a !== 4'b0010) $display("FAIL abort_restart: got %b want 0010", disp_a);
        else pass_cnt++;
    endtask

    task automatic test_last_row();
        @(negedge clk) start_b = 1'b1;
        @(negedge clk) start_b = 1'b0;
        for (int i = 0; i < 8; i++) begin
            frame();
            chk_cnt++;
            if (disp_b !== 4'b0001) $display("FAIL last_disp edge %0d: got %b want 0001", i + 1, disp_b);
            else pass_cnt++;
        end
        chk_cnt++;
        if (addr_b !== 3'd7 || busy_b !== 1'b1)
            $display("FAIL last_addr: got addr=%0d busy=%b want 7/1", addr_b, busy_b);
        else pass_cnt++;
        frame();
        chk_cnt++;
        if (disp_b !== 4'b0000 || done_b !== 1'b1 || addr_b !== 3'd7)
            $display("FAIL last_end: got disp=%b done=%b addr=%0d want 0000/1/7", disp_b, done_b, addr_b);
        else pass_cnt++;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom_a[i] = 8'h00;
        rom_a[0] = 8'h02;
        rom_a[1] = 8'h09;
        rom_a[2] = 8'h80;
        test_reset();
        test_basic();
        test_pause();
        test_ignore_start();
        test_abort();
        test_last_row();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
